// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: funct3 branch codes, forwarding selects,
// 2-bit BHT counter states and the saturating counter step function.
package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_RSV2 = 3'b010,
        F3_RSV3 = 3'b011,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_RSVD  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    localparam bht_ctr_e BHT_RESET_STATE = WNT;

    // Saturating step: taken moves towards ST, not-taken towards SNT.
    function automatic bht_ctr_e bht_ctr_next(input bht_ctr_e ctr, input logic taken);
        bht_ctr_e nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = bht_ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) nxt = bht_ctr_e'(ctr - 2'd1);
        end
        return nxt;
    endfunction

    function automatic logic is_legal_branch(input logic [2:0] funct3);
        return (funct3[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-side bundle for the branch resolve unit; master = pipeline, slave = resolve unit.
interface branch_resolve_unit_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   if_pc;
    logic              pred_taken;
    logic              id_valid;
    logic              id_is_branch;
    logic              id_stall;
    logic [2:0]        id_funct3;
    logic [XLEN-1:0]   id_pc;
    logic              id_pred_taken;
    logic [1:0]        fwd_sel_1;
    logic [1:0]        fwd_sel_2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   exmem_alu_data;
    logic [XLEN-1:0]   memwb_mem_data;
    logic              branch_taken;
    logic              mispredict;
    logic              illegal_branch;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] mp_count;

    modport master (
        output if_pc, id_valid, id_is_branch, id_stall, id_funct3, id_pc, id_pred_taken,
               fwd_sel_1, fwd_sel_2, rs1_data, rs2_data, exmem_alu_data, memwb_mem_data,
        input  pred_taken, branch_taken, mispredict, illegal_branch, br_count, mp_count
    );

    modport slave (
        input  if_pc, id_valid, id_is_branch, id_stall, id_funct3, id_pc, id_pred_taken,
               fwd_sel_1, fwd_sel_2, rs1_data, rs2_data, exmem_alu_data, memwb_mem_data,
        output pred_taken, branch_taken, mispredict, illegal_branch, br_count, mp_count
    );

endinterface

// File: rtl/branch_resolve_unit_bht_2bit.sv
// 2-bit saturating-counter branch history table with one read port and one update port.
// Only built when BRANCH_PREDICT_EN is defined.
`ifdef BRANCH_PREDICT_EN
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    bht_ctr_e r_ctr [DEPTH];

    // Read is purely combinational, so a same-cycle update is seen only after the edge.
    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= BHT_RESET_STATE;
            end
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= bht_ctr_next(r_ctr[i_upd_idx], i_upd_taken);
        end
    end

endmodule
`endif

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: operand forwarding, RV32I branch compare, mispredict and statistics.
// Optional feature macro BRANCH_PREDICT_EN: when defined, a 2-bit BHT supplies pred_taken.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int STAT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bru
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [XLEN-1:0]   w_op_a;
    logic [XLEN-1:0]   w_op_b;
    logic              w_cond;
    logic              w_legal;
    logic              w_active;
    logic              w_update;
    logic              w_taken;
    logic              w_mispredict;
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mp_count;

    always_comb begin
        w_op_a = bru.rs1_data;
        case (bru.fwd_sel_1)
            FWD_EXMEM: w_op_a = bru.exmem_alu_data;
            FWD_MEMWB: w_op_a = bru.memwb_mem_data;
            default:   w_op_a = bru.rs1_data;
        endcase
    end

    always_comb begin
        w_op_b = bru.rs2_data;
        case (bru.fwd_sel_2)
            FWD_EXMEM: w_op_b = bru.exmem_alu_data;
            FWD_MEMWB: w_op_b = bru.memwb_mem_data;
            default:   w_op_b = bru.rs2_data;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (bru.id_funct3)
            F3_BEQ:  w_cond = (w_op_a == w_op_b);
            F3_BNE:  w_cond = (w_op_a != w_op_b);
            F3_BLT:  w_cond = ($signed(w_op_a) <  $signed(w_op_b));
            F3_BGE:  w_cond = ($signed(w_op_a) >= $signed(w_op_b));
            F3_BLTU: w_cond = (w_op_a <  w_op_b);
            F3_BGEU: w_cond = (w_op_a >= w_op_b);
            default: w_cond = 1'b0;
        endcase
    end

    // Reserved funct3 resolves not-taken, so a predicted-taken one still redirects.
    assign w_legal      = is_legal_branch(bru.id_funct3);
    assign w_active     = bru.id_valid & bru.id_is_branch & ~bru.id_stall;
    assign w_update     = w_active & w_legal;
    assign w_taken      = w_update & w_cond;
    assign w_mispredict = w_active & (w_taken != bru.id_pred_taken);

    assign bru.branch_taken   = w_taken;
    assign bru.mispredict     = w_mispredict;
    assign bru.illegal_branch = w_active & ~w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else if (w_update) begin
            if (r_br_count != '1) r_br_count <= r_br_count + STAT_W'(1);
            if (w_mispredict && (r_mp_count != '1)) r_mp_count <= r_mp_count + STAT_W'(1);
        end
    end

    assign bru.br_count = r_br_count;
    assign bru.mp_count = r_mp_count;

`ifdef BRANCH_PREDICT_EN
    logic [1:0] w_rd_ctr;

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (bru.if_pc[IDX_W+1:2]),
        .o_rd_ctr    (w_rd_ctr),
        .i_upd_en    (w_update),
        .i_upd_idx   (bru.id_pc[IDX_W+1:2]),
        .i_upd_taken (w_taken)
    );

    assign bru.pred_taken = w_rd_ctr[1];
`else
    assign bru.pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (STAT_W=4 so saturation is reachable).
// Prediction expectations follow BRANCH_PREDICT_EN; without it pred_taken must stay 0.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

`ifdef BRANCH_PREDICT_EN
    localparam logic BP = 1'b1;
`else
    localparam logic BP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checkCount = 0;
    int   failCount  = 0;

    branch_resolve_unit_if #(.XLEN(32), .STAT_W(4)) bus ();

    branch_resolve_unit #(
        .XLEN      (32),
        .BHT_DEPTH (64),
        .STAT_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bru   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic isBranch, input logic stall,
                                 input logic [2:0] f3, input logic [31:0] pc, input logic pred,
                                 input logic [1:0] sel1, input logic [1:0] sel2,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] exmem, input logic [31:0] memwb);
        bus.id_valid       = valid;
        bus.id_is_branch   = isBranch;
        bus.id_stall       = stall;
        bus.id_funct3      = f3;
        bus.id_pc          = pc;
        bus.id_pred_taken  = pred;
        bus.fwd_sel_1      = sel1;
        bus.fwd_sel_2      = sel2;
        bus.rs1_data       = rs1;
        bus.rs2_data       = rs2;
        bus.exmem_alu_data = exmem;
        bus.memwb_mem_data = memwb;
    endtask

    task automatic goIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResolve(input string tag, input logic taken, input logic mp, input logic ill);
        #1;
        checkOutput({tag, "_taken"}, bus.branch_taken, taken);
        checkOutput({tag, "_mispredict"}, bus.mispredict, mp);
        checkOutput({tag, "_illegal"}, bus.illegal_branch, ill);
    endtask

    task automatic checkStats(input string tag, input int br, input int mp);
        checkOutput({tag, "_br_count"}, bus.br_count, br);
        checkOutput({tag, "_mp_count"}, bus.mp_count, mp);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.if_pc = 32'h100;
        goIdle();
        #1;
        checkOutput("reset_pred", bus.pred_taken, 0);
        checkStats("reset", 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic compares and forwarding
        applyStimulus(1, 1, 0, F3_BEQ, 32'h40, 0, FWD_RF, FWD_RF, 32'h5, 32'h5, 32'h0, 32'h0);
        checkResolve("beq", 1, 1, 0);
        nextCycle();
        checkStats("beq", 1, 1);

        applyStimulus(1, 1, 0, F3_BLT, 32'h80, 1, FWD_EXMEM, FWD_RF, 32'h7, 32'h1, 32'hFFFF_FFFF, 32'h0);
        checkResolve("blt_neg", 1, 0, 0);
        nextCycle();
        checkStats("blt_neg", 2, 1);

        applyStimulus(1, 1, 0, F3_BLTU, 32'h84, 1, FWD_EXMEM, FWD_RF, 32'h7, 32'h1, 32'hFFFF_FFFF, 32'h0);
        checkResolve("bltu_big", 0, 1, 0);
        nextCycle();
        checkStats("bltu_big", 3, 2);

        applyStimulus(1, 1, 0, F3_BGEU, 32'h88, 0, FWD_EXMEM, FWD_RF, 32'h7, 32'h1, 32'hFFFF_FFFF, 32'h0);
        checkResolve("bgeu_big", 1, 1, 0);
        nextCycle();

        applyStimulus(1, 1, 0, F3_BGE, 32'h8C, 1, FWD_RF, FWD_MEMWB, 32'h5, 32'h9, 32'h0, 32'h8000_0000);
        checkResolve("bge_min", 1, 0, 0);
        nextCycle();

        applyStimulus(1, 1, 0, F3_BNE, 32'h90, 0, FWD_RF, FWD_RF, 32'h3, 32'h3, 32'h0, 32'h0);
        checkResolve("bne_eq", 0, 0, 0);
        nextCycle();
        checkStats("after_bne", 6, 3);

        // Inactive instructions: no outputs, no updates
        applyStimulus(0, 1, 0, F3_BEQ, 32'h90, 1, FWD_RF, FWD_RF, 32'h3, 32'h3, 32'h0, 32'h0);
        checkResolve("invalid", 0, 0, 0);
        nextCycle();
        applyStimulus(1, 0, 0, F3_RSV2, 32'h90, 1, FWD_RF, FWD_RF, 32'h3, 32'h3, 32'h0, 32'h0);
        checkResolve("not_branch", 0, 0, 0);
        nextCycle();
        checkStats("inactive", 6, 3);

        // Training of index 0 and aliasing
        bus.if_pc = 32'h100;
        applyStimulus(1, 1, 0, F3_BEQ, 32'h100, 0, FWD_RF, FWD_RF, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checkOutput("train_pre", bus.pred_taken, 0);
        nextCycle();
        checkOutput("train_t1", bus.pred_taken, 32'(BP));
        nextCycle();
        nextCycle();
        checkOutput("train_t3", bus.pred_taken, 32'(BP));
        bus.if_pc = 32'h200;
        #1;
        checkOutput("alias_0x200", bus.pred_taken, 32'(BP));
        bus.if_pc = 32'h100;
        applyStimulus(1, 1, 0, F3_BNE, 32'h100, 1, FWD_RF, FWD_RF, 32'h0, 32'h0, 32'h0, 32'h0);
        checkResolve("train_nt", 0, 1, 0);
        nextCycle();
        checkOutput("train_nt1", bus.pred_taken, 32'(BP));
        nextCycle();
        checkOutput("train_nt2", bus.pred_taken, 0);
        checkStats("train", 11, 8);

        // Same-cycle read and update of index 4
        bus.if_pc = 32'h10;
        applyStimulus(1, 1, 0, F3_BEQ, 32'h10, 0, FWD_RF, FWD_RF, 32'h1, 32'h1, 32'h0, 32'h0);
        #1;
        checkOutput("rw_same_cycle", bus.pred_taken, 0);
        nextCycle();
        goIdle();
        #1;
        checkOutput("rw_next_cycle", bus.pred_taken, 32'(BP));

        // Stalled taken BNE updates exactly once
        bus.if_pc = 32'h20;
        applyStimulus(1, 1, 1, F3_BNE, 32'h20, 0, FWD_RF, FWD_RF, 32'h1, 32'h2, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkResolve("stalled", 0, 0, 0);
            nextCycle();
        end
        checkStats("stalled", 12, 9);
        checkOutput("stalled_pred", bus.pred_taken, 0);
        bus.id_stall = 1'b0;
        checkResolve("unstalled", 1, 1, 0);
        nextCycle();
        goIdle();
        #1;
        checkStats("unstalled", 13, 10);
        checkOutput("unstalled_pred", bus.pred_taken, 32'(BP));

        // Reserved funct3: illegal, redirect follows prediction, no updates
        applyStimulus(1, 1, 0, F3_RSV2, 32'h20, 1, FWD_RF, FWD_RF, 32'h1, 32'h1, 32'h0, 32'h0);
        checkResolve("illegal", 0, 1, 1);
        nextCycle();
        goIdle();
        #1;
        checkStats("illegal", 13, 10);
        checkOutput("illegal_pred", bus.pred_taken, 32'(BP));

        // Asynchronous reset mid-cycle with an active branch present
        applyStimulus(1, 1, 0, F3_BEQ, 32'h20, 0, FWD_RF, FWD_RF, 32'h1, 32'h1, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkStats("async_reset", 0, 0);
        checkOutput("async_reset_pred", bus.pred_taken, 0);
        checkOutput("reset_follow_taken", bus.branch_taken, 1);
        nextCycle();
        checkStats("held_reset", 0, 0);
        bus.if_pc = 32'h10;
        #1;
        checkOutput("reset_pred_idx4", bus.pred_taken, 0);
        rst_n = 1'b1;

        // Saturation of 4-bit statistics counters
        applyStimulus(1, 1, 0, F3_BEQ, 32'h300, 0, FWD_RF, FWD_RF, 32'h9, 32'h9, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) nextCycle();
        checkStats("sat_reach", 15, 15);
        nextCycle();
        checkStats("sat_hold", 15, 15);
        goIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised ID-stage branch resolution unit, the successor to the original unclocked branch compare logic. Selects forwarded operands, evaluates all six RV32I conditional-branch conditions at XLEN width, and compares the outcome with the IF-stage prediction to raise a redirect. Holds a 2-bit saturating-counter branch history table (BHT), read at IF and trained at ID. Also holds saturating branch and mispredict statistics counters.

## Interface
- XLEN, 32, operand and PC width
- BHT_DEPTH, 64, BHT entries (power of two, 4..1024); index width IDX_W = log2(BHT_DEPTH)
- STAT_W, 32, statistics counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch PC for prediction lookup
- pred_taken  out  1  IF-stage prediction for if_pc
- id_valid  in  1  ID stage holds a valid instruction
- id_is_branch  in  1  ID instruction is a conditional branch
- id_stall  in  1  ID stage stalled this cycle
- id_funct3  in  3  branch condition (instr[14:12])
- id_pc  in  XLEN  PC of ID instruction
- id_pred_taken  in  1  prediction carried down from IF
- fwd_sel_1, fwd_sel_2  in  2 each  operand source: 00 regfile, 01 EX/MEM ALU, 10 MEM/WB data, 11 reserved (regfile)
- rs1_data, rs2_data  in  XLEN each  register file read data
- exmem_alu_data  in  XLEN  EX/MEM forwarded ALU result
- memwb_mem_data  in  XLEN  MEM/WB forwarded writeback data
- branch_taken  out  1  resolved outcome
- mispredict  out  1  redirect required
- illegal_branch  out  1  funct3 is 010 or 011 on a branch
- br_count, mp_count  out  STAT_W each  resolved branches / mispredicts

## Operation
- Active branch = id_valid & id_is_branch & ~id_stall.
- Operand A/B select from fwd_sel_1/fwd_sel_2.
- Conditions: 000 BEQ A==B, 001 BNE A!=B, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
- Signed compare is full XLEN two's complement. No truncation.
- funct3 010/011: branch_taken=0, illegal_branch=1, mispredict=id_pred_taken, no BHT or stats update.
- branch_taken is 0 whenever the branch is not active.
- mispredict = active & (branch_taken != id_pred_taken).
- BHT: one 2-bit counter per entry, indexed by pc[IDX_W+1:2].
- pred_taken = counter[1] of the entry selected by if_pc.
- Training: on an active, legal branch, the id_pc entry increments (saturating at 11) if taken and decrements (saturating at 00) if not taken.
- Stats: br_count increments on every active, legal branch. mp_count increments when mispredict is also set. Both saturate at all-ones; they do not wrap.

## Timing
- branch_taken, mispredict, illegal_branch: combinational, same cycle as inputs.
- pred_taken: combinational read of BHT state.
- BHT and stats update on the rising edge ending the active cycle.
- A stalled branch produces no update. The update happens exactly once, on the non-stalled cycle.
- Same-cycle read/write to one index: pred_taken returns the pre-update value. The new value is visible the next cycle.
- Reset (async, any time including mid-update): all BHT entries to 01 (weakly not-taken), br_count and mp_count to 0. pred_taken reads 0 during and after reset.
- Other outputs follow their inputs during reset and are 0 while id_valid=0.

## Configuration
- BRANCH_PREDICT_EN defined: BHT instantiated as above.
- BRANCH_PREDICT_EN undefined: no BHT storage; pred_taken tied 0 (static not-taken); training logic removed. Comparator, mispredict and stats behave identically, so mispredict equals active & branch_taken when the pipeline carries id_pred_taken=0.

## Structure
- Shared package: funct3 branch encodings, fwd_sel encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB), 2-bit counter state constants (SNT=00, WNT=01, WT=10, ST=11).
- One sub-module: bht_2bit (counter array, read port, saturating update port, async reset). Omitted entirely when BRANCH_PREDICT_EN is undefined.

## Test plan
- BEQ, fwd 00/00, rs1=rs2=0x5, id_pred_taken=0 -> branch_taken=1, mispredict=1; next cycle br_count=1, mp_count=1.
- BLT with A=0xFFFFFFFF (via fwd_sel_1=01), B=0x1 -> taken; BLTU with the same operands -> not taken; BGEU with the same operands -> taken.
- Training, id_pc=0x100 taken three times from reset (01->10->11->11) -> pred_taken for if_pc=0x100 is 1. Then two not-taken updates -> counter 01, pred_taken=0. if_pc=0x200 (index 0 at depth 64) aliases to the same entry.
- Same-cycle read/update of index 4 (if_pc=id_pc=0x10), counter 01, taken -> pred_taken=0 that cycle, 1 the next.
- id_stall=1 for 3 cycles, then 0, on a taken BNE -> exactly one BHT and stats update. funct3=010 -> illegal_branch=1, no updates.
- Assert rst_n low mid-stream after several updates -> all entries 01 and counters 0 immediately, without waiting for clk. With STAT_W=4 forced to 15, one further branch -> br_count stays 15.
